// File: rtl/entry_pkg.sv
// Shared types and default constants for the digit entry front end.
package entry_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VERIFY  = 2'd2,
    DONE    = 2'd3
  } entry_state_t;

  localparam int DEFAULT_DEBOUNCE = 4;
  localparam int DEFAULT_DIGITS   = 4;

endpackage

// File: rtl/button_conditioner.sv
// One push-button: 2-FF synchronizer, stability debounce and rising-edge press pulse.
module button_conditioner
  import entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE  // must be >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_out;
  logic          level;
  logic          level_d;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta  <= 1'b0;
      sync_out   <= 1'b0;
      level      <= 1'b0;
      level_d    <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync_out  <= sync_meta;
      level_d   <= level;
      // Flip only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (sync_out == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == LAST_CNT) begin
        level      <= ~level;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

  // Both terms are flops, so the pulse is clean and exactly one cycle wide.
  assign press_pulse = level & ~level_d;

endmodule

// File: rtl/digit_entry_controller.sv
// Collects NUM_DIGITS button presses as bits, then fires a single start_verification pulse.
module digit_entry_controller
  import entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int NUM_DIGITS      = DEFAULT_DIGITS,
  parameter int CNT_W           = $clog2(NUM_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             btn1_raw,
  input  logic             btn2_raw,
  output logic             waiting_for_user,
  output logic             digit_bit,
  output logic             start_verification,
  output logic             collecting,
  output logic             done,
  output logic [CNT_W-1:0] digit_count,
  output logic             conflict
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_DIGITS);

  entry_state_t     state_reg;
  logic [1:0]       btn_raw_bus;
  logic [1:0]       press;
  logic             single_press;
  logic [CNT_W-1:0] count_next;

  // Index 0 is btn1 (digit '1'), index 1 is btn2 (digit '0').
  assign btn_raw_bus = {btn2_raw, btn1_raw};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cond (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw_bus[gi]),
        .press_pulse(press[gi])
      );
    end
  endgenerate

  assign single_press = press[0] ^ press[1];
  assign count_next   = digit_count + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg          <= IDLE;
      digit_count        <= '0;
      waiting_for_user   <= 1'b0;
      digit_bit          <= 1'b0;
      start_verification <= 1'b0;
      conflict           <= 1'b0;
    end else begin
      waiting_for_user   <= 1'b0;
      start_verification <= 1'b0;
      conflict           <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= COLLECT;
            digit_count <= '0;
          end
        end
        COLLECT: begin
          // A restart wins over any press arriving in the same cycle.
          if (start) begin
            digit_count <= '0;
          end else if (single_press) begin
            waiting_for_user <= 1'b1;
            digit_bit        <= press[0];
            digit_count      <= count_next;
            if (count_next == LAST_COUNT) state_reg <= VERIFY;
          end else if (&press) begin
            conflict <= 1'b1;
          end
        end
        VERIFY: begin
          start_verification <= 1'b1;
          state_reg          <= DONE;
        end
        DONE: begin
          if (start) begin
            state_reg   <= COLLECT;
            digit_count <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign collecting = (state_reg == COLLECT);
  assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_digit_entry_controller.sv
// Scoreboard bench for digit_entry_controller: expected digits queued at stimulus, checked on strobe.
module tb_digit_entry_controller;

  localparam int DEB    = 4;
  localparam int NDIG   = 4;
  localparam int CNT_W  = $clog2(NDIG + 1);

  logic             clk;
  logic             rst;
  logic             start;
  logic             btn1_raw;
  logic             btn2_raw;
  logic             waiting_for_user;
  logic             digit_bit;
  logic             start_verification;
  logic             collecting;
  logic             done;
  logic [CNT_W-1:0] digit_count;
  logic             conflict;

  typedef struct {
    logic bit_val;
    int   count;
  } exp_t;

  exp_t exp_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   wfu_seen = 0;
  int   sv_seen = 0;
  int   conflict_seen = 0;
  int   model_count = 0;
  bit   last_pending = 1'b0;

  digit_entry_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .NUM_DIGITS     (NDIG),
    .CNT_W          (CNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .btn1_raw          (btn1_raw),
    .btn2_raw          (btn2_raw),
    .waiting_for_user  (waiting_for_user),
    .digit_bit         (digit_bit),
    .start_verification(start_verification),
    .collecting        (collecting),
    .done              (done),
    .digit_count       (digit_count),
    .conflict          (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    bit   now_last;
    now_last = 1'b0;
    if (start_verification) begin
      sv_seen++;
      check_eq("sv_follows_last_digit", int'(last_pending), 1);
    end
    if (conflict) conflict_seen++;
    if (waiting_for_user) begin
      wfu_seen++;
      check_eq("strobe_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("digit_bit", int'(digit_bit), int'(e.bit_val));
        check_eq("digit_count", int'(digit_count), e.count);
        now_last = (e.count == NDIG);
        $display("strobe: digit_bit=%0d digit_count=%0d", digit_bit, digit_count);
      end
    end
    last_pending = now_last;
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_count = 0;
  endtask

  // which=1 drives btn1 (digit '1'), which=0 drives btn2 (digit '0').
  task automatic press(input logic which, input int hold, input int gap, input bit accept);
    if (accept) begin
      model_count++;
      exp_q.push_back('{which, model_count});
    end
    @(negedge clk);
    if (which) btn1_raw = 1'b1;
    else       btn2_raw = 1'b1;
    repeat (hold) @(negedge clk);
    btn1_raw = 1'b0;
    btn2_raw = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_wfu"}, int'(waiting_for_user), 0);
    check_eq({tag, "_digit_bit"}, int'(digit_bit), 0);
    check_eq({tag, "_sv"}, int'(start_verification), 0);
    check_eq({tag, "_collecting"}, int'(collecting), 0);
    check_eq({tag, "_done"}, int'(done), 0);
    check_eq({tag, "_count"}, int'(digit_count), 0);
    check_eq({tag, "_conflict"}, int'(conflict), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wfu_before;
    int conf_before;
    logic [3:0] seq_a;
    logic [3:0] seq_b;
    seq_a = 4'b1011;
    seq_b = 4'b0110;

    rst = 1'b0; start = 1'b0; btn1_raw = 1'b0; btn2_raw = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;

    // Presses in IDLE are ignored.
    press(1'b1, 8, 10, 1'b0);
    check_eq("idle_count", int'(digit_count), 0);
    check_eq("idle_collecting", int'(collecting), 0);

    // Basic sequence 1,0,1,1.
    do_start();
    check_eq("start_collecting", int'(collecting), 1);
    check_eq("start_count", int'(digit_count), 0);
    for (int i = 3; i >= 0; i--) press(seq_a[i], 8, 10, 1'b1);
    check_eq("seq_a_done", int'(done), 1);
    check_eq("seq_a_count", int'(digit_count), NDIG);
    check_eq("seq_a_sv_once", sv_seen, 1);

    // Presses in DONE are ignored.
    press(1'b0, 8, 10, 1'b0);
    check_eq("done_hold_count", int'(digit_count), NDIG);
    check_eq("done_hold_state", int'(done), 1);

    // Exact latency: raw rises just after edge 0, strobe follows edge 3+DEB.
    do_start();
    model_count++;
    exp_q.push_back('{1'b1, model_count});
    wfu_before = wfu_seen;
    @(posedge clk);
    #1 btn1_raw = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      #1 check_eq($sformatf("latency_edge%0d", e), int'(waiting_for_user), int'(e == 3 + DEB));
    end
    repeat (20) @(negedge clk);
    btn1_raw = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("held_single_strobe", wfu_seen - wfu_before, 1);
    check_eq("latency_count", int'(digit_count), 1);

    // Glitch of 3 cycles is filtered; 4 stable cycles is accepted.
    press(1'b0, 3, 12, 1'b0);
    check_eq("glitch_count", int'(digit_count), 1);
    press(1'b0, 4, 12, 1'b1);
    check_eq("min_pulse_count", int'(digit_count), 2);

    // Simultaneous presses: conflict only.
    conf_before = conflict_seen;
    wfu_before = wfu_seen;
    @(negedge clk);
    btn1_raw = 1'b1;
    btn2_raw = 1'b1;
    repeat (8) @(negedge clk);
    btn1_raw = 1'b0;
    btn2_raw = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("conflict_pulses", conflict_seen - conf_before, 1);
    check_eq("conflict_no_strobe", wfu_seen - wfu_before, 0);
    check_eq("conflict_count", int'(digit_count), 2);

    // Restart after 2 digits, then a full sequence 0,1,1,0.
    do_start();
    check_eq("restart_count", int'(digit_count), 0);
    check_eq("restart_collecting", int'(collecting), 1);
    for (int i = 3; i >= 0; i--) press(seq_b[i], 8, 10, 1'b1);
    check_eq("seq_b_sv_total", sv_seen, 2);
    check_eq("seq_b_done", int'(done), 1);

    // Asynchronous reset mid-sequence with a button held through release.
    do_start();
    for (int i = 0; i < 3; i++) press(1'b1, 8, 10, 1'b1);
    check_eq("pre_reset_count", int'(digit_count), 3);
    @(negedge clk);
    btn1_raw = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_idle_outputs("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_count = 0;
    wfu_before = wfu_seen;
    repeat (25) @(negedge clk);
    check_eq("post_reset_no_strobe", wfu_seen - wfu_before, 0);
    check_eq("post_reset_collecting", int'(collecting), 0);
    check_eq("post_reset_count", int'(digit_count), 0);
    btn1_raw = 1'b0;
    repeat (10) @(negedge clk);

    check_eq("scoreboard_drained", exp_q.size(), 0);
    check_eq("total_sv", sv_seen, 2);
    check_eq("total_conflict", conflict_seen, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
